mem_dump_tx: RTL

Post-run data-memory dump engine. After the pipelined CPU raises its end-of-program flag, the board logic pulses `start`. The block then walks a fixed window of data RAM word by word, splits each word into bytes and transmits them over a UART 8N1 line to the host. It sits downstream of the data memory, sharing the memory's read port, and runs on the same clock as the processor/RAM pair.

---
 rtl/dump_pkg.sv | 18 +
 rtl/uart_tx_byte.sv | 91 +++++++++
 rtl/mem_dump_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// Shared state encoding and UART frame constants for the post-run memory dump engine.
package dump_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5,
        DONE  = 3'd6
    } dump_state_t;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_STRIDE    = 4;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter with a valid/ready byte handoff and a registered tx line.
module uart_tx_byte
    import dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    dump_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // Ready in the last stop-bit cycle lets the next frame start with no idle gap.
    assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (valid) begin
                        shreg <= data;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (valid) begin
                            shreg <= data;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// Walks a window of data RAM and streams each word, little-endian byte order, over UART.
module mem_dump_tx
    import dump_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          NUM_WORDS    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] mem_addr,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [7:0]  byte_out
);

    dump_state_t state;
    logic [31:0] word_reg;
    logic [31:0] word_cnt;
    logic [1:0]  byte_idx;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    // Byte 0 is offered straight from RAM during LOAD so its start bit begins as LOAD ends.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = word_reg[{byte_idx, 3'b000} +: 8];
        case (state)
            LOAD: begin
                tx_valid = 1'b1;
                tx_data  = mem_rd_data[7:0];
            end
            START:   tx_valid = 1'b1;
            default: tx_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            mem_addr <= BASE_ADDR;
            word_cnt <= '0;
            byte_idx <= '0;
            byte_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_cnt <= '0;
                        mem_addr <= BASE_ADDR;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    word_reg <= mem_rd_data;
                    byte_idx <= 2'd0;
                    state    <= START;
                    if (tx_ready) begin
                        byte_out <= mem_rd_data[7:0];
                        byte_idx <= 2'd1;
                    end
                end
                START: begin
                    if (tx_ready) begin
                        byte_out <= tx_data;
                        if (byte_idx == 2'(BYTES_PER_WORD - 1))
                            state <= STOP;
                        else
                            byte_idx <= byte_idx + 2'd1;
                    end
                end
                // Wait for the last frame of the word to finish its stop bit.
                STOP: begin
                    if (tx_ready) begin
                        if (word_cnt < 32'(NUM_WORDS - 1)) begin
                            word_cnt <= word_cnt + 32'd1;
                            mem_addr <= mem_addr + 32'(WORD_STRIDE);
                            state    <= FETCH;
                        end else begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .reset(reset),
        .valid(tx_valid),
        .data (tx_data),
        .ready(tx_ready),
        .tx   (tx)
    );

endmodule
